// File: rtl/week_5_arb_pkg.sv
// Shared types and helpers for the four-requester round-robin arbiter.
package week_5_arb_pkg;

  localparam int N_REQ = 4;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_t;

  function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [1:0] idx);
    logic [N_REQ-1:0] onehot;
    case (idx)
      2'd0:    onehot = 4'b0001;
      2'd1:    onehot = 4'b0010;
      2'd2:    onehot = 4'b0100;
      2'd3:    onehot = 4'b1000;
      default: onehot = 4'b0000;
    endcase
    return onehot;
  endfunction

endpackage

// File: rtl/week_5_rr_pick_encoder.sv
// Combinational round-robin pick: rotate requests so ptr is bit 0,
// take the lowest set bit, then rotate the index back.
module week_5_rr_pick_encoder
  import week_5_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [1:0]       ptr,
  output logic [1:0]       pick_idx,
  output logic             pick_any
);

  logic [N_REQ-1:0] rot;
  logic [1:0]       sel;
  logic [1:0]       off;

  // Rotate by ptr, priority-encode from the top down so the lowest set bit wins last.
  always_comb begin
    rot      = '0;
    sel      = 2'd0;
    off      = 2'd0;
    pick_any = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      sel    = ptr + 2'(i);
      rot[i] = req[sel];
    end
    for (int i = N_REQ - 1; i >= 0; i--) begin
      off = rot[i] ? 2'(i) : off;
    end
    pick_any = |rot;
    pick_idx = ptr + off;
  end

endmodule

// File: rtl/week_5_rr_arbiter.sv
// Four-requester round-robin arbiter with owner release, withdrawal and
// hold-limit preemption; all outputs registered.
module week_5_rr_arbiter
  import week_5_arb_pkg::*;
#(
  parameter int HOLD_MAX = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] grant,
  output logic [1:0]       grant_idx,
  output logic             grant_valid
);

  localparam int HW = $clog2(HOLD_MAX);

  arb_state_t  state;
  logic [1:0]  ptr;
  logic [HW-1:0] hold_cnt;
  logic [1:0]  pick_idx;
  logic        pick_any;
  logic        release_now;

  week_5_rr_pick_encoder u_pick (
    .req      (req),
    .ptr      (ptr),
    .pick_idx (pick_idx),
    .pick_any (pick_any)
  );

  // Done, owner withdrawal and hold expiry all collapse into one release.
  always_comb begin
    release_now = done || !req[grant_idx] || (hold_cnt == HW'(HOLD_MAX - 1));
  end

  // Arbitration FSM with pointer, hold counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      ptr         <= 2'd0;
      hold_cnt    <= '0;
      grant       <= '0;
      grant_idx   <= 2'd0;
      grant_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          hold_cnt <= '0;
          if (pick_any) begin
            grant       <= idx_to_onehot(pick_idx);
            grant_idx   <= pick_idx;
            grant_valid <= 1'b1;
            state       <= ST_BUSY;
          end else begin
            grant       <= '0;
            grant_idx   <= 2'd0;
            grant_valid <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (release_now) begin
            ptr         <= grant_idx + 2'd1;
            hold_cnt    <= '0;
            grant       <= '0;
            grant_idx   <= 2'd0;
            grant_valid <= 1'b0;
            state       <= ST_IDLE;
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
            state    <= ST_BUSY;
          end
        end
        default: begin
          state       <= ST_IDLE;
          hold_cnt    <= '0;
          grant       <= '0;
          grant_idx   <= 2'd0;
          grant_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
